expr_eval_ctrl: RTL and testbench
=================================

Name: expr_eval_ctrl

Overview:
- Sequences an ASCII character stream into a single-digit arithmetic expression evaluator with '+' and '*', where '*' binds tighter than '+'.
- Checks the grammar digit (op digit)* '=' on the fly, accumulates the value, and returns one result per expression through a valid/ready result handshake.
- Sits between a character source, such as a UART receive buffer, and the consumer of the evaluated result.

Parameters:
- W, 8, width of result and accumulators; all arithmetic is modulo 2^W.

Ports:
- clk  input  1  clock, rising edge.
- clr  input  1  reset, asynchronous, active-low. All state clears while clr=0.
- in_valid  input  1  the character on in is valid.
- in_ready  output  1  block can accept a character this cycle.
- in  input  8  ASCII character.
- res_valid  output  1  result, err and ovf are valid.
- res_ready  input  1  consumer accepts the result.
- result  output  W  evaluated value; 0 when err=1.
- err  output  1  syntax error in the expression.
- ovf  output  1  sticky flag: an add or multiply exceeded 2^W-1 during the expression.

Behaviour:
- Reset values:
  - in_ready=1, res_valid=0, result=0, err=0, ovf=0.
  - State S_DIG; accumulators sum=0, term=0; pending op = '+'.
- Character accept: a character is consumed on a rising edge only when in_valid=1 and in_ready=1.
- in_ready = !res_valid. No character is accepted while a result is pending.
- States:
  - S_DIG (expecting a digit):
    - digit d, pending '+' -> term=d; go to S_OP.
    - digit d, pending '*' -> term=term*d; go to S_OP.
    - any other character, including '=' -> go to S_ERR. If that character was '=', go straight to S_OUT with err=1.
  - S_OP (expecting an operator):
    - '+' -> sum=sum+term; pending='+'; go to S_DIG.
    - '*' -> pending='*'; go to S_DIG.
    - '=' -> result=sum+term; go to S_OUT.
    - anything else -> S_ERR.
  - S_ERR: discard characters until '=' is accepted, then go to S_OUT with err=1 and result=0.
  - S_OUT: res_valid=1. result, err and ovf are held stable until res_valid & res_ready are both seen at a rising edge.
    - On that edge: res_valid goes to 0, err and ovf clear, sum=0, term=0, pending='+', state returns to S_DIG.
- Latency: res_valid rises on the same edge that accepts '='. result is registered, i.e. visible in the cycle after the accepting edge.
- Arithmetic:
  - Products and sums are computed at full width (2W bits) and then truncated to W bits.
  - ovf is set if any truncation discards a nonzero bit. It stays set until the result handshake completes.
  - err=1 forces result=0. ovf is still reported.
- Boundary conditions:
  - '=' arriving in S_DIG (empty expression or trailing operator) is an error.
  - Back-to-back expressions are supported with one cycle of in_ready=0 minimum. That cycle is the S_OUT cycle when res_ready is already high.
  - A reset mid-expression or mid-result discards everything immediately. The next character starts a fresh expression.
  - in_valid while in_ready=0: the character is not consumed, and the source must hold it.

Optional Feature:
- Macro: EXPR_EVAL_MULTI_DIGIT_EN.
- Defined:
  - A digit accepted in S_OP extends the current operand: opnd = opnd*10 + d, stay in S_OP.
  - The operand register is W bits wide and its overflow also sets ovf.
  - The completed operand is applied (assigned to term, or multiplied into term) when the next operator or '=' arrives.
- Undefined: a digit in S_OP is a syntax error and goes to S_ERR. This is single-digit behaviour only.

Test Plan:
- Precedence, W=8: "3+4*5=" with res_ready=1 -> res_valid pulse; result=23, err=0, ovf=0; in_ready=0 for exactly 1 cycle.
- Chained operators: "2*3*4+1=" -> result=25, err=0.
- Overflow: "9*9*9=" -> result=217 (729 mod 256), ovf=1, err=0. Following "1=" -> result=1, ovf=0.
- Error recovery:
  - "3++4=" -> err=1, result=0; then "7=" -> result=7, err=0.
  - "=" alone -> err=1.
- Backpressure and reset:
  - Hold res_ready=0 for 5 cycles after "6=" while in_valid=1 with '1' -> in_ready=0, result=6 stable, '1' not consumed.
  - Separately, pull clr low after "5*", then send "2=" -> result=2.
- Multi-digit:
  - "12+3=" -> result=15 with EXPR_EVAL_MULTI_DIGIT_EN defined.
  - Same stimulus -> err=1, result=0 without the macro.

Source files
------------

// File: rtl/expr_eval_ctrl.sv
// Streaming evaluator for ASCII "d(op d)*=" expressions with '+' and '*' ('*' binds tighter).
// Optional macro EXPR_EVAL_MULTI_DIGIT_EN enables multi-digit decimal operands.
module expr_eval_ctrl #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] result,
    output logic         err,
    output logic         ovf
);

    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_MUL  = 8'h2A;
    localparam logic [7:0] CH_EQ   = 8'h3D;

    typedef enum logic [1:0] {S_DIG, S_OP, S_ERR, S_OUT} state_t;

    state_t         state;
    logic [W-1:0]   sum;
    logic [W-1:0]   term;
    logic           pend_mul;
    logic           accept;
    logic           is_digit;
    logic [W-1:0]   dval;
    logic [2*W-1:0] eff_full;
    logic [2*W-1:0] sum_full;
    logic [W-1:0]   eff;
    logic           eff_ovf;
    logic           sum_ovf;

    assign in_ready = !res_valid;
    assign accept   = in_valid && in_ready;
    assign is_digit = (in >= CH_0) && (in <= CH_9);
    assign dval     = W'(in[3:0]);

`ifdef EXPR_EVAL_MULTI_DIGIT_EN
    logic [W-1:0]   opnd;
    logic [2*W-1:0] opnd_full;
    logic           opnd_ovf;

    assign opnd_full = {{W{1'b0}}, opnd} * {{W{1'b0}}, W'(10)} + {{W{1'b0}}, dval};
    assign opnd_ovf  = |opnd_full[2*W-1:W];
    // The pending operand is folded into term only when its terminating operator arrives.
    assign eff_full  = pend_mul ? ({{W{1'b0}}, term} * {{W{1'b0}}, opnd})
                                : {{W{1'b0}}, opnd};
`else
    logic [2*W-1:0] dig_prod;
    logic           dig_ovf;

    assign dig_prod = {{W{1'b0}}, term} * {{W{1'b0}}, dval};
    assign dig_ovf  = |dig_prod[2*W-1:W];
    assign eff_full = {{W{1'b0}}, term};
`endif

    assign eff      = eff_full[W-1:0];
    assign eff_ovf  = |eff_full[2*W-1:W];
    assign sum_full = {{W{1'b0}}, sum} + {{W{1'b0}}, eff};
    assign sum_ovf  = |sum_full[2*W-1:W];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= S_DIG;
            sum       <= '0;
            term      <= '0;
            pend_mul  <= 1'b0;
            result    <= '0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            res_valid <= 1'b0;
`ifdef EXPR_EVAL_MULTI_DIGIT_EN
            opnd      <= '0;
`endif
        end else if (state == S_OUT) begin
            if (res_ready) begin
                res_valid <= 1'b0;
                err       <= 1'b0;
                ovf       <= 1'b0;
                sum       <= '0;
                term      <= '0;
                pend_mul  <= 1'b0;
                state     <= S_DIG;
            end
        end else if (accept) begin
            case (state)
                S_DIG: begin
                    if (is_digit) begin
`ifdef EXPR_EVAL_MULTI_DIGIT_EN
                        opnd <= dval;
`else
                        term <= pend_mul ? dig_prod[W-1:0] : dval;
                        ovf  <= ovf | (pend_mul & dig_ovf);
`endif
                        state <= S_OP;
                    end else if (in == CH_EQ) begin
                        result    <= '0;
                        err       <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= S_OUT;
                    end else begin
                        state <= S_ERR;
                    end
                end
                S_OP: begin
                    if (in == CH_PLUS) begin
                        sum      <= sum_full[W-1:0];
                        pend_mul <= 1'b0;
                        ovf      <= ovf | eff_ovf | sum_ovf;
                        state    <= S_DIG;
                    end else if (in == CH_MUL) begin
                        term     <= eff;
                        pend_mul <= 1'b1;
                        ovf      <= ovf | eff_ovf;
                        state    <= S_DIG;
                    end else if (in == CH_EQ) begin
                        result    <= sum_full[W-1:0];
                        ovf       <= ovf | eff_ovf | sum_ovf;
                        err       <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= S_OUT;
`ifdef EXPR_EVAL_MULTI_DIGIT_EN
                    end else if (is_digit) begin
                        opnd <= opnd_full[W-1:0];
                        ovf  <= ovf | opnd_ovf;
`endif
                    end else begin
                        state <= S_ERR;
                    end
                end
                S_ERR: begin
                    if (in == CH_EQ) begin
                        result    <= '0;
                        err       <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= S_OUT;
                    end
                end
                default: state <= S_DIG;
            endcase
        end
    end

endmodule

// File: tb/tb_expr_eval_ctrl.sv
// Directed bench for expr_eval_ctrl; expectations follow EXPR_EVAL_MULTI_DIGIT_EN if defined.
module tb_expr_eval_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in = 8'h00;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic [W-1:0] result;
    logic         err;
    logic         ovf;

    int vectors = 0;
    int miscompares = 0;

    expr_eval_ctrl #(.W(W)) dut (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .err       (err),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic send(input byte c);
        int n;
        n = 0;
        in_valid = 1'b1;
        in = c;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!in_ready) begin
            miscompares++;
            $display("FAIL send_timeout: in_ready=%0b required 1 for char 0x%0h", in_ready, c);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    // Sends s (ending in '=') with res_ready high and checks the one-cycle result window.
    task automatic run_expr(input string s, input logic [W-1:0] exp_res,
                            input logic exp_err, input logic exp_ovf);
        res_ready = 1'b1;
        send_str(s);
        vectors++;
        if (res_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s valid: res_valid=%0b in_ready=%0b required 1/0", s, res_valid, in_ready);
        end
        vectors++;
        if (result !== exp_res || err !== exp_err || ovf !== exp_ovf) begin
            miscompares++;
            $display("FAIL %s value: result=%0d err=%0b ovf=%0b required %0d/%0b/%0b",
                     s, result, err, ovf, exp_res, exp_err, exp_ovf);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL %s release: res_valid=%0b in_ready=%0b err=%0b ovf=%0b required 0/1/0/0",
                     s, res_valid, in_ready, err, ovf);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0 || result !== '0 || err !== 1'b0 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: in_ready=%0b res_valid=%0b result=%0d err=%0b ovf=%0b required 1/0/0/0/0",
                     in_ready, res_valid, result, err, ovf);
        end
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic test_precedence;
        run_expr("3+4*5=", 8'd23, 1'b0, 1'b0);
        run_expr("2*3*4+1=", 8'd25, 1'b0, 1'b0);
    endtask

    task automatic test_overflow;
        run_expr("9*9*9=", 8'd217, 1'b0, 1'b1);
        run_expr("1=", 8'd1, 1'b0, 1'b0);
        run_expr("9*9+9*9+9*9+9*9=", 8'd68, 1'b0, 1'b1);
    endtask

    task automatic test_error;
        run_expr("3++4=", 8'd0, 1'b1, 1'b0);
        run_expr("7=", 8'd7, 1'b0, 1'b0);
        run_expr("=", 8'd0, 1'b1, 1'b0);
        run_expr("5+=", 8'd0, 1'b1, 1'b0);
        run_expr("4x2=", 8'd0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure;
        res_ready = 1'b0;
        send_str("6=");
        in = 8'h31;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (in_ready !== 1'b0 || res_valid !== 1'b1 || result !== 8'd6 || err !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_%0d: in_ready=%0b res_valid=%0b result=%0d err=%0b required 0/1/6/0",
                         i, in_ready, res_valid, result, err);
            end
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_release: res_valid=%0b in_ready=%0b required 0/1", res_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // The held '1' must have been taken exactly once.
        run_expr("=", 8'd1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid;
        send_str("5*");
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        run_expr("2=", 8'd2, 1'b0, 1'b0);

        res_ready = 1'b0;
        send_str("4=");
        vectors++;
        if (res_valid !== 1'b1 || result !== 8'd4) begin
            miscompares++;
            $display("FAIL pre_reset_result: res_valid=%0b result=%0d required 1/4", res_valid, result);
        end
        clr = 1'b0;
        #1;
        vectors++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_result: res_valid=%0b in_ready=%0b result=%0d required 0/1/0",
                     res_valid, in_ready, result);
        end
        @(negedge clk);
        clr = 1'b1;
        run_expr("8*3=", 8'd24, 1'b0, 1'b0);
    endtask

    task automatic test_multi_digit;
`ifdef EXPR_EVAL_MULTI_DIGIT_EN
        run_expr("12+3=", 8'd15, 1'b0, 1'b0);
        run_expr("300=", 8'd44, 1'b0, 1'b1);
        run_expr("12*12*2=", 8'd32, 1'b0, 1'b1);
`else
        run_expr("12+3=", 8'd0, 1'b1, 1'b0);
        run_expr("300=", 8'd0, 1'b1, 1'b0);
`endif
    endtask

    initial begin
        test_reset;
        test_precedence;
        test_overflow;
        test_error;
        test_backpressure;
        test_reset_mid;
        test_multi_digit;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
